// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze, load-use bubble, EX redirect flush.
// Optional cycle counter of stall/flush activity enabled by defining PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MemReadE,
    input  logic [4:0] r3_addrE,
    input  logic [4:0] rs_addrD,
    input  logic [4:0] rt_addrD,
    input  logic       pc_redirectE,
    input  logic       mem_reqM,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       StallE,
    output logic       FlushE,
    output logic       StallM,
    output logic       FlushW,
    output logic       busy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int CW = ($clog2(MEM_LAT + 1) < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_M1 = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;
    localparam bit HAS_LAT = (MEM_LAT != 0);

    typedef enum logic {RUN, WAIT} st_t;

    st_t           st_reg, st_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          mem_stall;
    logic          load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg       <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            st_reg       <= st_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign mem_stall = ((st_reg == RUN) && mem_reqM && HAS_LAT) ||
                       ((st_reg == WAIT) && (wait_cnt_reg != '0));

    assign load_use = MemReadE && (r3_addrE != 5'd0) &&
                      ((r3_addrE == rs_addrD) || (r3_addrE == rt_addrD));

    always_comb begin
        st_next       = st_reg;
        wait_cnt_next = wait_cnt_reg;
        case (st_reg)
            RUN: begin
                if (mem_reqM && HAS_LAT) begin
                    st_next       = WAIT;
                    wait_cnt_next = LAT_M1;
                end
            end
            WAIT: begin
                // Count reaching zero marks the release cycle; the MEM instruction leaves at this edge.
                if (wait_cnt_reg != '0) begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end else begin
                    st_next = RUN;
                end
            end
            default: begin
                st_next       = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        StallM = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            // A frozen ID_EX keeps any redirect alive until the release cycle.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (pc_redirectE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign busy = (st_reg == WAIT);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (StallF || FlushE || FlushD) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational priority table plus memory-wait, redirect and reset sequences.
// Output vectors are packed {StallF,StallD,FlushD,StallE,FlushE,StallM,FlushW,busy}.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MemReadE;
    logic [4:0] r3_addrE, rs_addrD, rt_addrD;
    logic       pc_redirectE;
    logic       mem_reqM;

    logic StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, busy;
    logic StallF0, StallD0, FlushD0, StallE0, FlushE0, StallM0, FlushW0, busy0;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt0;
`endif

    logic [7:0] outs, outs0;
    assign outs  = {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, busy};
    assign outs0 = {StallF0, StallD0, FlushD0, StallE0, FlushE0, StallM0, FlushW0, busy0};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadE(MemReadE), .r3_addrE(r3_addrE),
        .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .pc_redirectE(pc_redirectE),
        .mem_reqM(mem_reqM), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushW(FlushW), .busy(busy)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_hazard_ctrl #(.MEM_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .MemReadE(MemReadE), .r3_addrE(r3_addrE),
        .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .pc_redirectE(pc_redirectE),
        .mem_reqM(mem_reqM), .StallF(StallF0), .StallD(StallD0), .FlushD(FlushD0),
        .StallE(StallE0), .FlushE(FlushE0), .StallM(StallM0), .FlushW(FlushW0), .busy(busy0)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt0)
`endif
    );

    typedef struct {
        logic       mr;
        logic [4:0] r3;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       redir;
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_LU    = 8'b1100_1000;
    localparam logic [7:0] O_REDIR = 8'b0010_1000;
    localparam logic [7:0] O_MEM   = 8'b1101_0110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] r3, input logic [4:0] rs,
                         input logic [4:0] rt, input logic redir, input logic mreq);
        MemReadE = mr; r3_addrE = r3; rs_addrD = rs; rt_addrD = rt;
        pc_redirectE = redir; mem_reqM = mreq;
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, O_NONE};
        vecs[1] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, O_LU};
        vecs[2] = '{1'b1, 5'd5,  5'd3,  5'd5,  1'b0, O_LU};
        vecs[3] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, O_NONE};
        vecs[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b0, O_NONE};
        vecs[5] = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b0, O_NONE};
        vecs[6] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, O_REDIR};
        vecs[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, O_REDIR};
        vecs[8] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, O_LU};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        check("reset_outs", 32'(outs), 32'(O_NONE));
        check("reset_outs_lat0", 32'(outs0), 32'(O_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].mr, vecs[i].r3, vecs[i].rs, vecs[i].rt, vecs[i].redir, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            check($sformatf("vec%0d_lat0", i), 32'(outs0), 32'(vecs[i].exp));
            next_cycle();
        end

        // Three-cycle memory access; load-use in cycle 2 must be masked.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk); check("mem_c1", 32'(outs), 32'(O_MEM));
        check("mem_c1_lat0", 32'(outs0), 32'(O_NONE));
        next_cycle();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1);
        @(negedge clk); check("mem_c2_masked_lu", 32'(outs), 32'(O_MEM | 8'h01));
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk); check("mem_c3_release", 32'(outs), 32'h01);
        check("mem_c3_lat0", 32'(outs0), 32'(O_NONE));
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk); check("mem_c4_idle", 32'(outs), 32'(O_NONE));
        next_cycle();

        // Redirect raised while the access freezes the pipe; honoured in the release cycle.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        @(negedge clk); check("redir_mem_c1", 32'(outs), 32'(O_MEM));
        check("redir_mem_c1_lat0", 32'(outs0), 32'(O_REDIR));
        next_cycle();
        @(negedge clk); check("redir_mem_c2", 32'(outs), 32'(O_MEM | 8'h01));
        next_cycle();
        @(negedge clk); check("redir_mem_c3", 32'(outs), 32'(O_REDIR | 8'h01));
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk); check("redir_mem_c4", 32'(outs), 32'(O_NONE));
        next_cycle();

        // Asynchronous reset in the middle of a wait.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1; check("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1; check("async_rst_busy", 32'(outs), 32'(O_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk); check("after_rst_run", 32'(outs), 32'(O_NONE));
        next_cycle();

`ifdef PIPE_STALL_CNT_EN
        check("cnt_after_rst", stall_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
            next_cycle();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        next_cycle();
        check("cnt_four", stall_cnt, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
